mux_sel_arbiter: RTL
====================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter that drives the select of the 2:1 datapath mux (sel=1 passes a, sel=0 passes b).
//  Two requesters (A, B) request the shared mux output; one is granted at a time and sel follows the grant.
//  Sits directly upstream of the mux; grant and sel are registered and change together on the same edge.
// PARAMETERS
//  HOLD_MAX  8                      max consecutive grant cycles before forced rotation (only with ARB_TIMEOUT_EN); >=1
//  CNT_W     $clog2(HOLD_MAX+1)     hold-counter width (derived, do not override)
// PORTS
//  clk      in   1  single clock, rising edge
//  reset    in   1  asynchronous, active-high reset
//  req_a    in   1  requester A wants the mux; held high for the whole transfer
//  req_b    in   1  requester B wants the mux; held high for the whole transfer
//  gnt_a    out  1  A owns the mux
//  gnt_b    out  1  B owns the mux
//  sel      out  1  mux select: 1 = a, 0 = b
//  busy     out  1  gnt_a | gnt_b (registered)
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; gnt_a=0, gnt_b=0, busy=0, sel=0; last_served=B (A wins the first tie).
//  States: IDLE, GNT_A, GNT_B. All outputs are registered; a request seen at edge N gives a grant visible after edge N+1.
//  IDLE: req_a&req_b -> grant the requester != last_served; single req -> grant it; none -> stay IDLE.
//  GNT_A: stays while req_a=1. req_a=0 -> re-arbitrate in the same cycle with last_served=A:
//   req_b=1 -> GNT_B (back-to-back, no idle cycle); else -> IDLE. GNT_B mirrors this.
//  sel: 1 in GNT_A, 0 in GNT_B; in IDLE holds its last value (no glitch on the mux).
//  gnt_a and gnt_b are never both 1 (one-hot-or-zero invariant; assert in sim).
//  last_served updates on every grant-release edge.
//  Reset mid-grant drops grants at once (async); after release, arbitration restarts with A priority.
//  Requests that rise and fall between edges are not captured (no latching of pulses).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold_cnt counts cycles in GNT_x, cleared on entry.
//   When hold_cnt reaches HOLD_MAX-1 and the other req=1 -> forced switch to the other grant on the next edge,
//   even if the owner still requests. The preempted owner re-requests and is queued as the non-last-served side.
//   If the other req=0, the owner keeps the grant and hold_cnt saturates at HOLD_MAX-1.
//  ARB_TIMEOUT_EN undefined: no counter logic; a grant is held for as long as its req stays high.
// STRUCTURE
//  Shared package mux_arb_pkg: state typedef arb_state_t {IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10};
//   constants SEL_A=1'b1, SEL_B=1'b0.
//  One sub-module, arb_hold_counter (clear / enable / saturating counter with terminal-count flag);
//   instantiated only under ARB_TIMEOUT_EN.
// TESTING
//  1 reset=1 with req_a=req_b=1 -> all outputs 0, sel=0; release reset -> gnt_a=1, sel=1 after 1 edge.
//  2 req_a only for 5 cycles, then drop -> gnt_a high 5 cycles, then IDLE; sel stays 1 in IDLE.
//  3 req_a=req_b=1 held, A drops after 3 grant cycles -> gnt_b asserts on the very next edge (no gap), sel=0.
//  4 Alternate simultaneous requests 4 rounds -> grant order A,B,A,B; gnt_a&gnt_b never 1.
//  5 ARB_TIMEOUT_EN, HOLD_MAX=4, req_a,req_b both held -> A granted exactly 4 cycles, then B 4, then A.
//     Without the macro -> A held indefinitely.
//  6 Assert reset mid-GNT_B -> gnt_b, busy fall without a clock; after release with both req -> A granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin mux-select arbiter.
`timescale 1ns/1ps

package mux_arb_pkg;

    // Arbiter state; encoding is fixed so the grant bits read directly off the state.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_t;

    // Which requester owned the mux most recently; the other one wins a tie.
    typedef enum logic {
        SIDE_B = 1'b0,
        SIDE_A = 1'b1
    } side_t;

    // Mux select encoding: 1 passes input a, 0 passes input b.
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage : mux_arb_pkg

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the two mux requesters and the arbiter.
// master = requester side (drives requests), slave = arbiter side (drives grants and sel).
`timescale 1ns/1ps

interface mux_sel_arbiter_if;

    logic req_a;   // requester A wants the mux, held for the whole transfer
    logic req_b;   // requester B wants the mux, held for the whole transfer
    logic gnt_a;   // A owns the mux
    logic gnt_b;   // B owns the mux
    logic sel;     // mux select: 1 = a, 0 = b
    logic busy;    // gnt_a | gnt_b

    modport master (
        output req_a,
        output req_b,
        input  gnt_a,
        input  gnt_b,
        input  sel,
        input  busy
    );

    modport slave (
        input  req_a,
        input  req_b,
        output gnt_a,
        output gnt_b,
        output sel,
        output busy
    );

endinterface : mux_sel_arbiter_if

// File: rtl/arb_hold_counter.sv
// Saturating hold counter for the arbiter timeout. Clear has priority over enable;
// the count stops at MAX-1 and o_tc is high while it sits there.
`timescale 1ns/1ps

module arb_hold_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [W-1:0] TC_VAL = W'(MAX - 1);

    logic [W-1:0] r_cnt;

    // Count grant cycles, restarting on every new grant and saturating at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_tc = (r_cnt == TC_VAL);

endmodule : arb_hold_counter

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving the select of a 2:1 datapath mux.
// Grants, sel and busy are registered and change together on one edge.
// Optional feature: define ARB_TIMEOUT_EN to force rotation after HOLD_MAX grant
// cycles when the other side is waiting.
// Reset is asynchronous assert; release is expected to be synchronised upstream.
`timescale 1ns/1ps

module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    mux_sel_arbiter_if.slave   arb
);

    // Reject illegal configurations at elaboration time.
    if (HOLD_MAX < 1 || CNT_W != $clog2(HOLD_MAX + 1)) begin : g_param_err
        $error("mux_sel_arbiter: HOLD_MAX must be >= 1 and CNT_W must not be overridden");
    end

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    side_t      r_last_served;
    side_t      w_last_nxt;
    logic       r_gnt_a;
    logic       r_gnt_b;
    logic       r_sel;
    logic       r_busy;
    logic       w_hold_tc;

`ifdef ARB_TIMEOUT_EN
    logic w_hold_clear;
    logic w_hold_en;

    // Restart the count on every state change, count while a grant is held.
    assign w_hold_clear = (w_state_nxt != r_state);
    assign w_hold_en    = (r_state != IDLE);

    arb_hold_counter #(
        .MAX (HOLD_MAX),
        .W   (CNT_W)
    ) u_hold_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_hold_clear),
        .i_en    (w_hold_en),
        .o_tc    (w_hold_tc)
    );
`else
    // Without the timeout a grant is kept for as long as its request stays high.
    assign w_hold_tc = 1'b0;
`endif

    // Next-state and round-robin bookkeeping; a release re-arbitrates in the same cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_last_nxt  = r_last_served;
        unique case (r_state)
            IDLE: begin
                if (arb.req_a && arb.req_b) begin
                    w_state_nxt = (r_last_served == SIDE_A) ? GNT_B : GNT_A;
                end else if (arb.req_a) begin
                    w_state_nxt = GNT_A;
                end else if (arb.req_b) begin
                    w_state_nxt = GNT_B;
                end
            end
            GNT_A: begin
                if (!arb.req_a || (w_hold_tc && arb.req_b)) begin
                    w_last_nxt  = SIDE_A;
                    w_state_nxt = arb.req_b ? GNT_B : IDLE;
                end
            end
            GNT_B: begin
                if (!arb.req_b || (w_hold_tc && arb.req_a)) begin
                    w_last_nxt  = SIDE_B;
                    w_state_nxt = arb.req_a ? GNT_A : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, grant, select and busy registers all load from the next state on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_last_served <= SIDE_B;
            r_gnt_a       <= 1'b0;
            r_gnt_b       <= 1'b0;
            r_sel         <= SEL_B;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_served <= w_last_nxt;
            r_gnt_a       <= (w_state_nxt == GNT_A);
            r_gnt_b       <= (w_state_nxt == GNT_B);
            r_busy        <= (w_state_nxt != IDLE);
            // In IDLE sel keeps its last value so the mux output does not glitch.
            if (w_state_nxt == GNT_A) begin
                r_sel <= SEL_A;
            end else if (w_state_nxt == GNT_B) begin
                r_sel <= SEL_B;
            end
        end
    end

    assign arb.gnt_a = r_gnt_a;
    assign arb.gnt_b = r_gnt_b;
    assign arb.sel   = r_sel;
    assign arb.busy  = r_busy;

    // The two grants are one-hot-or-zero at all times.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) !(r_gnt_a && r_gnt_b));

endmodule : mux_sel_arbiter
